// File: rtl/interrupt_priority_sequencer.sv
// Wishbone interrupt controller: latches level/edge sources, arbitrates by index and sequences claim/EOI.
// Optional IPS_NESTING_EN allows higher-priority sources to preempt in-service ones (nested ACTIVE bits).
module interrupt_priority_sequencer #(
  parameter int WB_DWIDTH = 32,
  parameter int WB_SWIDTH = 4,
  parameter int NUM_SRC   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [31:0]          i_wb_adr,
  input  logic [WB_SWIDTH-1:0] i_wb_sel,
  input  logic                 i_wb_we,
  input  logic [WB_DWIDTH-1:0] i_wb_dat,
  output logic [WB_DWIDTH-1:0] o_wb_dat,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  output logic                 o_wb_ack,
  output logic                 o_wb_err,
  input  logic [NUM_SRC-1:0]   i_int_src,
  output logic                 o_irq
);

  // state   | meaning
  // WB_IDLE | accepts writes (acked same cycle) and starts reads
  // WB_RD   | read data registered, ack while stb, then back to idle
  typedef enum logic {WB_IDLE, WB_RD} wb_state_t;

  localparam int IW = 5;

  wb_state_t          state_q, state_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] edge_sel_q, edge_sel_d;
  logic [NUM_SRC-1:0] edge_pend_q, edge_pend_d;
  logic [NUM_SRC-1:0] active_q, active_d;
  logic [NUM_SRC-1:0] src_d1_q, src_d1_d;
  logic [31:0]        rd_dat_q, rd_dat_d;
  logic               irq_q, irq_d;

  logic [31:0]        wr_word;
  logic [7:0]         adr;
  logic [NUM_SRC-1:0] pending, eligible, best_oh, eoi_oh, one;
  logic [IW-1:0]      best;
  logic               acc, wr_en, rd_start, claim_ok, claim;
  logic [31:0]        rd_mux;

  generate
    if (WB_DWIDTH == 128) begin : g_wide
      assign wr_word = i_wb_dat[32*i_wb_adr[3:2] +: 32];
    end else begin : g_narrow
      assign wr_word = i_wb_dat[31:0];
    end
  endgenerate

  assign adr      = i_wb_adr[7:0];
  assign acc      = i_wb_cyc & i_wb_stb;
  assign wr_en    = acc & i_wb_we & (state_q == WB_IDLE);
  assign rd_start = acc & ~i_wb_we & (state_q == WB_IDLE);
  assign one      = {{(NUM_SRC-1){1'b0}}, 1'b1};

  // Edge sources show their latched bit, level sources show the live line.
  assign pending  = (edge_pend_q & edge_sel_q) | (i_int_src & ~edge_sel_q);
  assign eligible = pending & enable_q & ~active_q;
  assign best_oh  = one << best;
  assign eoi_oh   = one << wr_word[4:0];

  always_comb begin
    best = '0;
    for (int i = NUM_SRC-1; i >= 0; i--) begin
      if (eligible[i]) best = IW'(i);
    end
  end

`ifdef IPS_NESTING_EN
  logic [IW-1:0] cur_pri;
  always_comb begin
    cur_pri = IW'(NUM_SRC);
    for (int i = NUM_SRC-1; i >= 0; i--) begin
      if (active_q[i]) cur_pri = IW'(i);
    end
  end
  assign claim_ok = |eligible;
  assign irq_d    = (|eligible) && (best < cur_pri);
`else
  assign claim_ok = (|eligible) && ~(|active_q);
  assign irq_d    = (|eligible) && ~(|active_q);
`endif

  assign claim = rd_start && (adr == 8'h0C) && claim_ok;

  always_comb begin
    case (adr)
      8'h00:   rd_mux = {{(32-NUM_SRC){1'b0}}, pending};
      8'h04:   rd_mux = {{(32-NUM_SRC){1'b0}}, enable_q};
      8'h08:   rd_mux = {{(32-NUM_SRC){1'b0}}, edge_sel_q};
      8'h0C:   rd_mux = claim ? {1'b1, 26'd0, best} : 32'd0;
      8'h14:   rd_mux = {{(32-NUM_SRC){1'b0}}, active_q};
      8'h18:   rd_mux = {31'd0, irq_q};
      default: rd_mux = 32'h2233_4455;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    enable_d   = enable_q;
    edge_sel_d = edge_sel_q;
    active_d   = active_q;
    rd_dat_d   = rd_dat_q;
    src_d1_d   = i_int_src;
    // A new edge coincident with its own claim survives: set wins over clear.
    edge_pend_d = ((edge_pend_q & ~(claim ? best_oh : '0)) |
                   (i_int_src & ~src_d1_q)) & edge_sel_q;
    if (claim) active_d = active_q | best_oh;
    if (wr_en) begin
      case (adr)
        8'h04:   enable_d   = wr_word[NUM_SRC-1:0];
        8'h08:   edge_sel_d = wr_word[NUM_SRC-1:0];
        8'h10:   active_d   = active_q & ~eoi_oh;
        default: ;
      endcase
    end
    case (state_q)
      WB_IDLE: if (rd_start) begin
        state_d  = WB_RD;
        rd_dat_d = rd_mux;
      end
      WB_RD:   state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= WB_IDLE;
      enable_q    <= '0;
      edge_sel_q  <= '0;
      edge_pend_q <= '0;
      active_q    <= '0;
      src_d1_q    <= '0;
      rd_dat_q    <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      edge_sel_q  <= edge_sel_d;
      edge_pend_q <= edge_pend_d;
      active_q    <= active_d;
      src_d1_q    <= src_d1_d;
      rd_dat_q    <= rd_dat_d;
      irq_q       <= irq_d;
    end
  end

  assign o_wb_dat = {(WB_DWIDTH/32){rd_dat_q}};
  assign o_wb_ack = wr_en | ((state_q == WB_RD) & i_wb_stb);
  assign o_wb_err = 1'b0;
  assign o_irq    = irq_q;

  logic unused_ok;
  assign unused_ok = ^{i_wb_sel, i_wb_adr[31:8], wr_word[31:NUM_SRC]};

endmodule
